// File: rtl/reset_sequencer_pkg.sv
// flexsoc_rst_pkg: shared state encoding, cause bit indices and sizing helper for the reset sequencer
package flexsoc_rst_pkg;
  typedef enum logic [1:0] {
    WAIT_LOCK   = 2'd0,
    POR_STRETCH = 2'd1,
    SYS_STRETCH = 2'd2,
    RUN         = 2'd3
  } seq_state_t;
  localparam int CAUSE_POR = 0;
  localparam int CAUSE_BTN = 1;
  localparam int CAUSE_PLL = 2;
  localparam int CAUSE_SW  = 3;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/reset_sequencer_debounce.sv
// rst_debounce: button synchroniser, stability filter and one-cycle press pulse
// Ports: i_clk clock, i_rst_n sync active-low reset, i_btn_n async button (active low),
//        o_press one-cycle pulse when the accepted state goes released -> pressed
module rst_debounce #(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_n,
  output logic o_press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic          r_s1, r_s2, r_acc, r_press;
  logic [CW-1:0] r_cnt;
  logic          w_hit;
  // r_cnt counts consecutive samples that disagree with the accepted state
  assign w_hit = (r_s2 != r_acc) && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_acc   <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_s1    <= i_btn_n;
      r_s2    <= r_s1;
      r_cnt   <= (r_s2 == r_acc || w_hit) ? '0 : r_cnt + CW'(1);
      r_acc   <= w_hit ? r_s2 : r_acc;
      r_press <= w_hit & ~r_s2;
    end
  end
  assign o_press = r_press;
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: orders PORESETn/HRESETn release from PLL lock, button and software requests
// Ports: CLK clock, RESETn sync active-low reset, PLL_LOCKED async lock flags, BUTTONn async button,
//        SYSRESETREQ core reset request, CAUSE_CLR cause clear pulse, PORESETn/HRESETn resets,
//        RST_CAUSE sticky causes {SW, PLL, BTN, POR}, SEQ_STATE debug state
module reset_sequencer
  import flexsoc_rst_pkg::*;
#(
  parameter int NUM_PLL         = 2,
  parameter int POR_CYCLES      = 255,
  parameter int SYS_CYCLES      = 16,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic [NUM_PLL-1:0] PLL_LOCKED,
  input  logic               BUTTONn,
  input  logic               SYSRESETREQ,
  input  logic               CAUSE_CLR,
  output logic               PORESETn,
  output logic               HRESETn,
  output logic [3:0]         RST_CAUSE,
  output logic [1:0]         SEQ_STATE
);
  localparam int CW = $clog2(max3(POR_CYCLES, SYS_CYCLES, DEBOUNCE_CYCLES) + 1);
  localparam logic [CW-1:0] POR_LOAD = CW'(POR_CYCLES - 1);
  localparam logic [CW-1:0] SYS_LOAD = CW'(SYS_CYCLES - 1);
  logic [NUM_PLL-1:0] r_pll_s1, r_pll_s2;
  logic               w_lock_ok, w_press, w_zero;
  seq_state_t         r_state, w_next;
  logic [CW-1:0]      r_cnt, w_cnt;
  logic [3:0]         w_set, r_cause;
  logic               r_poresetn, r_hresetn;
  assign w_lock_ok = &r_pll_s2;
  assign w_zero    = (r_cnt == '0);
  rst_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .i_clk  (CLK),
    .i_rst_n(RESETn),
    .i_btn_n(BUTTONn),
    .o_press(w_press)
  );
  always_comb begin
    w_next = r_state;
    w_cnt  = w_zero ? r_cnt : r_cnt - CW'(1);
    w_set  = '0;
    unique case (r_state)
      WAIT_LOCK: begin
        w_next = w_lock_ok ? POR_STRETCH : WAIT_LOCK;
        w_cnt  = w_lock_ok ? POR_LOAD : w_cnt;
      end
      POR_STRETCH: begin
        w_next = !w_lock_ok ? WAIT_LOCK : (!w_press && w_zero) ? SYS_STRETCH : POR_STRETCH;
        w_cnt  = !w_lock_ok ? w_cnt : w_press ? POR_LOAD : w_zero ? SYS_LOAD : w_cnt;
      end
      SYS_STRETCH: begin
        w_set[CAUSE_PLL] = !w_lock_ok;
        w_set[CAUSE_BTN] = w_lock_ok & w_press;
        w_next = (!w_lock_ok || w_press) ? WAIT_LOCK : w_zero ? RUN : SYS_STRETCH;
      end
      RUN: begin
        // lock loss and press are both recorded when they coincide; software cause only when neither fires
        w_set[CAUSE_PLL] = !w_lock_ok;
        w_set[CAUSE_BTN] = w_press;
        w_set[CAUSE_SW]  = w_lock_ok & ~w_press & SYSRESETREQ;
        w_next = (!w_lock_ok || w_press) ? WAIT_LOCK : SYSRESETREQ ? SYS_STRETCH : RUN;
        w_cnt  = w_set[CAUSE_SW] ? SYS_LOAD : w_cnt;
      end
      default: w_next = WAIT_LOCK;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_pll_s1   <= '0;
      r_pll_s2   <= '0;
      r_state    <= WAIT_LOCK;
      r_cnt      <= '0;
      r_cause    <= 4'b0001;
      r_poresetn <= 1'b0;
      r_hresetn  <= 1'b0;
    end else begin
      r_pll_s1   <= PLL_LOCKED;
      r_pll_s2   <= r_pll_s1;
      r_state    <= w_next;
      r_cnt      <= w_cnt;
      r_cause    <= CAUSE_CLR ? w_set : (r_cause | w_set);
      r_poresetn <= (w_next == SYS_STRETCH) || (w_next == RUN);
      r_hresetn  <= (w_next == RUN);
    end
  end
  assign PORESETn  = r_poresetn;
  assign HRESETn   = r_hresetn;
  assign RST_CAUSE = r_cause;
  assign SEQ_STATE = r_state;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed scenario tasks plus randomized run against a deadline-based reference model
module tb_reset_sequencer;
  localparam int NP = 2, P = 8, S = 4, D = 16;
  logic          CLK = 1'b0, RESETn = 1'b0, BUTTONn = 1'b1, SYSRESETREQ = 1'b0, CAUSE_CLR = 1'b0;
  logic [NP-1:0] PLL_LOCKED = '0;
  logic          PORESETn, HRESETn;
  logic [3:0]    RST_CAUSE;
  logic [1:0]    SEQ_STATE;
  int n_chk = 0, n_fail = 0;

  always #5 CLK = ~CLK;

  reset_sequencer #(.NUM_PLL(NP), .POR_CYCLES(P), .SYS_CYCLES(S), .DEBOUNCE_CYCLES(D)) dut (
    .CLK(CLK), .RESETn(RESETn), .PLL_LOCKED(PLL_LOCKED), .BUTTONn(BUTTONn),
    .SYSRESETREQ(SYSRESETREQ), .CAUSE_CLR(CAUSE_CLR), .PORESETn(PORESETn),
    .HRESETn(HRESETn), .RST_CAUSE(RST_CAUSE), .SEQ_STATE(SEQ_STATE)
  );

  // Reference model: phases end at absolute cycle deadlines; synchronisers are plain delay lines
  int         cyc = 0, m_mode = 0, m_dl = 0, run_len = 0;
  logic [3:0] m_cause = 4'b0001;
  bit         l1, l2, b1 = 1, b2 = 1, acc = 1, m_press;
  always @(posedge CLK) begin : model
    bit         lk, pr;
    logic [3:0] st;
    cyc++;
    if (!RESETn) begin
      m_mode = 0; m_cause = 4'b0001; l1 = 0; l2 = 0; b1 = 1; b2 = 1; acc = 1; run_len = 0; m_press = 0;
    end else begin
      lk = l2; pr = m_press; st = '0;
      case (m_mode)
        0: if (lk) begin m_mode = 1; m_dl = cyc + P; end
        1: if (!lk) m_mode = 0;
           else if (pr) m_dl = cyc + P;
           else if (cyc == m_dl) begin m_mode = 2; m_dl = cyc + S; end
        2: begin
          if (!lk) st[2] = 1; else if (pr) st[1] = 1;
          if (!lk || pr) m_mode = 0; else if (cyc == m_dl) m_mode = 3;
        end
        default: begin
          st[2] = !lk; st[1] = pr;
          if (!lk || pr) m_mode = 0;
          else if (SYSRESETREQ) begin st[3] = 1; m_mode = 2; m_dl = cyc + S; end
        end
      endcase
      m_cause = CAUSE_CLR ? st : (m_cause | st);
      m_press = 0;
      if (b2 != acc) begin
        run_len++;
        if (run_len == D) begin acc = b2; run_len = 0; m_press = !b2; end
      end else run_len = 0;
      l2 = l1; l1 = &PLL_LOCKED; b2 = b1; b1 = BUTTONn;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic test_reset;
    RESETn = 0; PLL_LOCKED = '0;
    cycles(5);
    n_chk++;
    if ({PORESETn, HRESETn, RST_CAUSE, SEQ_STATE} !== 8'b00_0001_00) begin
      n_fail++; $display("FAIL reset_state: got %b expected 00000100", {PORESETn, HRESETn, RST_CAUSE, SEQ_STATE});
    end
    RESETn = 1;
    cycles(3);
  endtask

  task automatic test_cold_start;
    int tp = -1, th = -1;
    PLL_LOCKED = 2'b11;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (tp < 0 && PORESETn) tp = i;
      if (tp > 0 && th < 0 && HRESETn) th = i;
    end
    n_chk++;
    if (tp != 11) begin n_fail++; $display("FAIL cold_poresetn_rise: got %0d expected 11", tp); end
    n_chk++;
    if (th - tp != 4) begin n_fail++; $display("FAIL cold_hresetn_gap: got %0d expected 4", th - tp); end
    n_chk++;
    if (RST_CAUSE !== 4'b0001) begin n_fail++; $display("FAIL cold_cause: got %b expected 0001", RST_CAUSE); end
  endtask

  task automatic test_lock_loss;
    int ta = -1, tb = -1, tc = -1;
    PLL_LOCKED[1] = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge CLK);
      if (i == 1) PLL_LOCKED[1] = 1'b1;
      if (ta < 0 && !PORESETn) ta = i;
      if (ta > 0 && tb < 0 && PORESETn) tb = i;
      if (tb > 0 && tc < 0 && HRESETn) tc = i;
    end
    n_chk++;
    if (ta != 3) begin n_fail++; $display("FAIL lock_loss_latency: got %0d expected 3", ta); end
    n_chk++;
    if (tb != 12 || tc != 16) begin n_fail++; $display("FAIL lock_relock_seq: got %0d/%0d expected 12/16", tb, tc); end
    n_chk++;
    if (RST_CAUSE !== 4'b0101) begin n_fail++; $display("FAIL lock_cause: got %b expected 0101", RST_CAUSE); end
  endtask

  task automatic test_button_glitch;
    int bad = 0;
    BUTTONn = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge CLK);
      if (i == 10) BUTTONn = 1;
      if (!HRESETn || SEQ_STATE !== 2'd3) bad++;
    end
    n_chk++;
    if (bad != 0 || RST_CAUSE !== 4'b0101) begin
      n_fail++; $display("FAIL button_glitch: got %0d reset cycles cause %b expected 0 and 0101", bad, RST_CAUSE);
    end
  endtask

  task automatic test_button_press;
    int tw = -1, tp = -1, th = -1;
    BUTTONn = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (tw < 0 && SEQ_STATE == 2'd0) tw = i;
      if (tw > 0 && tp < 0 && PORESETn) tp = i;
      if (tp > 0 && th < 0 && HRESETn) th = i;
    end
    BUTTONn = 1;
    n_chk++;
    if (tw != 19) begin n_fail++; $display("FAIL press_wait_lock: got %0d expected 19", tw); end
    n_chk++;
    if (tp != 28 || th != 32) begin n_fail++; $display("FAIL press_por_seq: got %0d/%0d expected 28/32", tp, th); end
    n_chk++;
    if (RST_CAUSE !== 4'b0111) begin n_fail++; $display("FAIL press_cause: got %b expected 0111", RST_CAUSE); end
    cycles(30);
  endtask

  task automatic test_clear_race;
    SYSRESETREQ = 1; CAUSE_CLR = 1;
    @(negedge CLK);
    SYSRESETREQ = 0; CAUSE_CLR = 0;
    n_chk++;
    if (RST_CAUSE !== 4'b1000 || SEQ_STATE !== 2'd2) begin
      n_fail++; $display("FAIL clear_race: got cause %b state %0d expected 1000 state 2", RST_CAUSE, SEQ_STATE);
    end
    cycles(4);
    CAUSE_CLR = 1;
    @(negedge CLK);
    CAUSE_CLR = 0;
    n_chk++;
    if (RST_CAUSE !== 4'b0000 || !HRESETn) begin
      n_fail++; $display("FAIL clear_alone: got cause %b hresetn %b expected 0000 1", RST_CAUSE, HRESETn);
    end
  endtask

  task automatic test_sw_reset;
    int first = -1, lows = 0, porlow = 0;
    SYSRESETREQ = 1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLK);
      if (i == 1) SYSRESETREQ = 0;
      if (!HRESETn) begin lows++; if (first < 0) first = i; end
      if (!PORESETn) porlow++;
    end
    n_chk++;
    if (first != 1 || lows != 4) begin n_fail++; $display("FAIL sw_hresetn: got start %0d len %0d expected 1 4", first, lows); end
    n_chk++;
    if (porlow != 0) begin n_fail++; $display("FAIL sw_poresetn: got %0d low cycles expected 0", porlow); end
    n_chk++;
    if (RST_CAUSE !== 4'b1000) begin n_fail++; $display("FAIL sw_cause: got %b expected 1000", RST_CAUSE); end
  endtask

  task automatic test_simultaneous;
    int th = -1;
    CAUSE_CLR = 1;
    @(negedge CLK);
    CAUSE_CLR = 0;
    BUTTONn = 0;
    cycles(16);
    PLL_LOCKED = 2'b00;
    cycles(2);
    SYSRESETREQ = 1;
    @(negedge CLK);
    SYSRESETREQ = 0; PLL_LOCKED = 2'b11;
    n_chk++;
    if (SEQ_STATE !== 2'd0 || RST_CAUSE !== 4'b0110) begin
      n_fail++; $display("FAIL simultaneous: got state %0d cause %b expected 0 0110", SEQ_STATE, RST_CAUSE);
    end
    cycles(5);
    BUTTONn = 1;
    for (int i = 1; i <= 100 && th < 0; i++) begin @(negedge CLK); if (HRESETn) th = i; end
    n_chk++;
    if (th < 0) begin n_fail++; $display("FAIL simultaneous_recover: got timeout expected HRESETn high"); end
  endtask

  task automatic test_reset_mid_por;
    int th = -1;
    PLL_LOCKED = 2'b00;
    cycles(3);
    PLL_LOCKED = 2'b11;
    cycles(5);
    n_chk++;
    if (SEQ_STATE !== 2'd1) begin n_fail++; $display("FAIL mid_por_state: got %0d expected 1", SEQ_STATE); end
    RESETn = 0;
    @(negedge CLK);
    RESETn = 1;
    n_chk++;
    if ({PORESETn, HRESETn, RST_CAUSE, SEQ_STATE} !== 8'b00_0001_00) begin
      n_fail++; $display("FAIL mid_por_reset: got %b expected 00000100", {PORESETn, HRESETn, RST_CAUSE, SEQ_STATE});
    end
    for (int i = 1; i <= 40 && th < 0; i++) begin @(negedge CLK); if (HRESETn) th = i; end
    n_chk++;
    if (th != 15) begin n_fail++; $display("FAIL mid_por_resequence: got %0d expected 15", th); end
  endtask

  task automatic test_random;
    logic [7:0] exp_v, got_v;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      exp_v = {m_mode >= 2, m_mode == 3, m_cause, 2'(m_mode)};
      got_v = {PORESETn, HRESETn, RST_CAUSE, SEQ_STATE};
      n_chk++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL random_cycle %0d: got %b expected %b", i, got_v, exp_v);
      end
      if ($urandom_range(0, 249) == 0) PLL_LOCKED = 2'($urandom_range(0, 2));
      else if (PLL_LOCKED != 2'b11 && $urandom_range(0, 5) == 0) PLL_LOCKED = 2'b11;
      if ($urandom_range(0, 59) == 0) BUTTONn = ~BUTTONn;
      if ($urandom_range(0, 29) == 0) SYSRESETREQ = ~SYSRESETREQ;
      CAUSE_CLR = ($urandom_range(0, 63) == 0);
      RESETn = ($urandom_range(0, 799) != 0);
    end
    RESETn = 1; CAUSE_CLR = 0; SYSRESETREQ = 0; BUTTONn = 1; PLL_LOCKED = 2'b11;
  endtask

  initial begin
    test_reset;
    test_cold_start;
    test_lock_loss;
    test_button_glitch;
    test_button_press;
    test_clear_race;
    test_sw_reset;
    test_simultaneous;
    test_reset_mid_por;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
